// File: rtl/mmio_port_unit_if.sv
// mmio_port_unit_if: data-memory bus seen by the MMIO port unit.
// Master is the CPU datapath; slave is the MMIO block.
interface mmio_port_unit_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address,
    output WriteData,
    output MemWrite,
    output MemRead,
    input  ReadData,
    input  Hit
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemWrite,
    input  MemRead,
    output ReadData,
    output Hit
  );
endinterface

// File: rtl/mmio_port_unit.sv
// mmio_port_unit: port out/in, edge-capture status and irq on the data bus.
// Define MMIO_TIMER_EN to build the compare timer at offsets 0x10-0x18.
module mmio_port_unit #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            reset,
  mmio_port_unit_if.slave bus,
  input  logic [7:0]      PortIn,
  output logic [31:0]     PortOut,
  output logic            Irq
);

  logic [2:0]  off;
  logic        wr;
  logic        rd;
  logic        sel_out;
  logic        sel_in;
  logic        sel_stat;
  logic        sel_mask;
  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  prev;
  logic [7:0]  rise;
  logic [7:0]  edge_stat;
  logic [7:0]  edge_mask;
  logic [7:0]  stat_clr;
  logic        tmr_irq;
  logic [31:0] rdata;
  logic        unused_addr;

  assign unused_addr = ^bus.Address[1:0];

  assign bus.Hit = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign off     = bus.Address[4:2];
  assign wr      = bus.Hit & bus.MemWrite;
  assign rd      = bus.Hit & bus.MemRead;

  assign sel_out  = (off == 3'd0);
  assign sel_in   = (off == 3'd1);
  assign sel_stat = (off == 3'd2);
  assign sel_mask = (off == 3'd3);

  assign rise     = sync2 & ~prev;
  assign stat_clr = (wr & sel_stat) ? bus.WriteData[7:0] : 8'h00;

  // output port register, written directly by stores to offset 0x00
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      PortOut <= '0;
    else if (wr && sel_out)
      PortOut <= bus.WriteData;
  end

  // two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // sticky rising-edge status; a new edge beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      edge_stat <= '0;
    else
      edge_stat <= (edge_stat & ~stat_clr) | rise;
  end

  // interrupt enable mask for the edge status bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      edge_mask <= '0;
    else if (wr && sel_mask)
      edge_mask <= bus.WriteData[7:0];
  end

`ifdef MMIO_TIMER_EN
  logic        sel_cnt;
  logic        sel_cmp;
  logic        sel_ctrl;
  logic [31:0] tmr_count;
  logic [31:0] tmr_cmp;
  logic        tmr_en;
  logic        tmr_arl;
  logic        tmr_match;
  logic        tmr_tie;
  logic        match_now;
  logic        match_clr;

  assign sel_cnt   = (off == 3'd4);
  assign sel_cmp   = (off == 3'd5);
  assign sel_ctrl  = (off == 3'd6);
  assign match_now = tmr_en & (tmr_count == tmr_cmp);
  assign match_clr = wr & sel_ctrl & bus.WriteData[2];
  assign tmr_irq   = tmr_match & tmr_tie;

  // counter: cpu write wins over reload, reload wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmr_count <= '0;
    else if (wr && sel_cnt)
      tmr_count <= bus.WriteData;
    else if (tmr_en)
      tmr_count <= (match_now && tmr_arl) ? 32'd0 : tmr_count + 32'd1;
  end

  // compare value register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmr_cmp <= '0;
    else if (wr && sel_cmp)
      tmr_cmp <= bus.WriteData;
  end

  // control bits EN, AUTORELOAD and TIE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_en  <= 1'b0;
      tmr_arl <= 1'b0;
      tmr_tie <= 1'b0;
    end else if (wr && sel_ctrl) begin
      tmr_en  <= bus.WriteData[0];
      tmr_arl <= bus.WriteData[1];
      tmr_tie <= bus.WriteData[3];
    end
  end

  // sticky match flag; a new match beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmr_match <= 1'b0;
    else
      tmr_match <= (tmr_match & ~match_clr) | match_now;
  end
`else
  assign tmr_irq = 1'b0;
`endif

  // interrupt request, registered from the combined sources
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Irq <= 1'b0;
    else
      Irq <= (|(edge_stat & edge_mask)) | tmr_irq;
  end

  // load data mux; zero when not selected or on unmapped offsets
  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        sel_out:  rdata = PortOut;
        sel_in:   rdata = {24'b0, sync2};
        sel_stat: rdata = {24'b0, edge_stat};
        sel_mask: rdata = {24'b0, edge_mask};
`ifdef MMIO_TIMER_EN
        sel_cnt:  rdata = tmr_count;
        sel_cmp:  rdata = tmr_cmp;
        sel_ctrl: rdata = {28'b0, tmr_tie, tmr_match,
                           tmr_arl, tmr_en};
`endif
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;

endmodule
